dual_slot_dmem_arbiter: RTL and testbench
=========================================

// Module: dual_slot_dmem_arbiter
// PURPOSE
//   Shares the single-ported data memory between the two issue-slot subdatapaths in the M stage.
//   - Issue slot 1 is always older than slot 2.
//   - When only one slot requests, its access is passed straight through to dmem.
//   - When both slots request in the same cycle, slot 1 is served first and slot 2 one cycle later.
//     Stall_m is asserted for that cycle so the pipeline holds.
//   - Sits between the subdatapath memory ports (memadr/memwd/memwrite/memenable) and data_memory.
// PARAMETERS
//   AW     32  address width
//   DW     32  data width
//   CNT_W  16  width of the dual-access conflict counter
// PORTS
//   clk              in   1      pipeline clock
//   reset            in   1      asynchronous, active-low reset
//   req_1            in   1      slot 1 M-stage memory enable (lw or sw)
//   we_1             in   1      slot 1 write (sw)
//   adr_1            in   AW     slot 1 address
//   wd_1             in   DW     slot 1 write data
//   req_2            in   1      slot 2 M-stage memory enable (lw or sw)
//   we_2             in   1      slot 2 write (sw)
//   adr_2            in   AW     slot 2 address
//   wd_2             in   DW     slot 2 write data
//   rd_1             out  DW     slot 1 read data
//   rd_2             out  DW     slot 2 read data
//   stall_m          out  1      hold F..M stages this cycle
//   dmem_write       out  1      data_memory write enable
//   dmem_address     out  AW     data_memory address
//   dmem_write_data  out  DW     data_memory write data
//   dmem_read_data   in   DW     data_memory read data (combinational read)
//   conflict_cnt     out  CNT_W  number of dual-access cycles since reset
// BEHAVIOUR
//   States: IDLE, SERVE2.
//   On reset:
//     - state=IDLE
//     - hold registers (adr2_q, wd2_q, we2_q, rd1_q) = 0
//     - conflict_cnt = 0
//     - stall_m = 0, dmem_write = 0
//   IDLE, single request:
//     - dmem port = requesting slot (slot 1 when req_1, otherwise slot 2)
//     - dmem_write = req & we of that slot
//     - rd_x = dmem_read_data
//     - stall_m = 0; zero added latency
//   IDLE, no request: dmem_address = adr_2, dmem_write_data = wd_2, dmem_write = 0.
//   IDLE, req_1 & req_2:
//     - dmem port = slot 1; stall_m = 1 (combinational)
//     - at posedge: latch slot 2 request into adr2_q/wd2_q/we2_q, latch dmem_read_data into rd1_q
//     - conflict_cnt += 1, saturating at all-ones
//     - go to SERVE2
//   SERVE2:
//     - dmem port = latched slot 2 request; dmem_write = we2_q
//     - rd_1 = rd1_q, rd_2 = dmem_read_data
//     - stall_m = 0; req inputs are ignored (they are the same held instruction)
//     - go to IDLE unconditionally
//   Ordering:
//     - slot 1 write then slot 2 read, same address: the read returns the new data.
//     - slot 2 read then slot 1 write: cannot occur; slot 1 is always served first.
//     - both slots write the same address: slot 2's value persists.
//   rd_x for a non-requesting slot = dmem_read_data (don't-care to the consumer).
//   Back-to-back conflicts (IDLE->SERVE2->IDLE->SERVE2): one stall cycle per conflict; no bubble between.
//   Reset asserted mid-SERVE2: the pending slot 2 access is dropped; no dmem write occurs after reset.
// STRUCTURE
//   Package dmem_arb_pkg:
//     - localparams ST_IDLE=1'b0, ST_SERVE2=1'b1
//     - typedef of the slot request bundle {we, adr, wd}
//   Sub-module dmem_req_latch: async-active-low-reset, enable-gated capture of the slot 2 bundle plus rd1_q.
//   The arbiter top holds the FSM, port mux and counter.
// TESTING
//   1. Reset low 3 cycles, then release; no req -> stall_m=0, dmem_write=0, conflict_cnt=0.
//   2. req_1 lw adr 0x40 (mem=0xAAAA) only -> same cycle rd_1=0xAAAA, stall_m=0.
//   3. req_1 sw 0x40<-0x1234 and req_2 lw 0x40 ->
//        cycle0: stall_m=1, dmem_write=1
//        cycle1: rd_2=0x1234, stall_m=0, conflict_cnt=1
//   4. Both lw (0x40=0x11, 0x44=0x22) ->
//        cycle1: rd_1=0x11 (from rd1_q), rd_2=0x22
//   5. Both sw to 0x50 (slot 1 0x1, slot 2 0x2) -> later lw 0x50 returns 0x2.
//   6. Conflict, then reset low during SERVE2 -> state=IDLE, no write to adr_2, stall_m=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dual-slot data-memory arbiter.
// Holds the FSM state codes and the slot request bundle {we, adr, wd}.
package dmem_arb_pkg;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_SERVE2 = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] adr;
    logic [ARB_DW-1:0] wd;
  } slot_req_t;

endpackage

// File: rtl/dmem_req_latch.sv
// Captures the deferred slot 2 request and slot 1's read data on a conflict.
// Contents are only consumed in the cycle right after a capture.
module dmem_req_latch
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  slot_req_t         req,
  input  logic [ARB_DW-1:0] rd,
  output slot_req_t         req_q,
  output logic [ARB_DW-1:0] rd_q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q <= '0;
      rd_q  <= '0;
    end else if (en) begin
      req_q <= req;
      rd_q  <= rd;
    end
  end

endmodule

// File: rtl/dual_slot_dmem_arbiter.sv
// Arbitrates the single-ported data memory between two M-stage issue slots.
// Slot 1 (older) wins a conflict; slot 2 is replayed next cycle under a one-cycle stall.
module dual_slot_dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW    = ARB_AW,
  parameter int DW    = ARB_DW,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_1,
  input  logic             we_1,
  input  logic [AW-1:0]    adr_1,
  input  logic [DW-1:0]    wd_1,
  input  logic             req_2,
  input  logic             we_2,
  input  logic [AW-1:0]    adr_2,
  input  logic [DW-1:0]    wd_2,
  output logic [DW-1:0]    rd_1,
  output logic [DW-1:0]    rd_2,
  output logic             stall_m,
  output logic             dmem_write,
  output logic [AW-1:0]    dmem_address,
  output logic [DW-1:0]    dmem_write_data,
  input  logic [DW-1:0]    dmem_read_data,
  output logic [CNT_W-1:0] conflict_cnt
);

  // The request bundle type is sized by the package widths.
  if (AW != ARB_AW || DW != ARB_DW) begin : g_width_check
    $error("dual_slot_dmem_arbiter: AW/DW must match dmem_arb_pkg widths");
  end

  logic      state;
  logic      state_nxt;
  logic      conflict;
  slot_req_t req2_bundle;
  slot_req_t req2_q;
  logic [DW-1:0] rd1_q;

  assign conflict    = (state == ST_IDLE) && req_1 && req_2;
  assign req2_bundle = '{we: we_2, adr: adr_2, wd: wd_2};

  dmem_req_latch u_req_latch (
    .clk   (clk),
    .reset (reset),
    .en    (conflict),
    .req   (req2_bundle),
    .rd    (dmem_read_data),
    .req_q (req2_q),
    .rd_q  (rd1_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    if (state == ST_IDLE && conflict) state_nxt = ST_SERVE2;
  end

  // Write enable and stall are forced low while reset is held so a
  // dropped slot 2 access can never reach memory.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    dmem_address    = adr_2;
    dmem_write_data = wd_2;
    dmem_write      = 1'b0;
    stall_m         = 1'b0;
    rd_1            = dmem_read_data;
    rd_2            = dmem_read_data;
    if (state == ST_SERVE2) begin
      dmem_address    = req2_q.adr;
      dmem_write_data = req2_q.wd;
      dmem_write      = req2_q.we;
      rd_1            = rd1_q;
    end else if (req_1) begin
      dmem_address    = adr_1;
      dmem_write_data = wd_1;
      dmem_write      = we_1;
      stall_m         = req_2;
    end else if (req_2) begin
      dmem_write      = we_2;
    end
    dmem_write = dmem_write & reset;
    stall_m    = stall_m & reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               conflict_cnt <= '0;
    else if (conflict && conflict_cnt != '1)  conflict_cnt <= conflict_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_dual_slot_dmem_arbiter.sv
// Self-checking bench: a transaction-level model of "slot 1 then slot 2"
// memory semantics is compared against the arbiter driving a behavioural memory.
module tb_dual_slot_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_1, we_1, req_2, we_2;
  logic [31:0] adr_1, wd_1, adr_2, wd_2;
  logic [31:0] rd_1, rd_2;
  logic        stall_m, dmem_write;
  logic [31:0] dmem_address, dmem_write_data, dmem_read_data;
  logic [15:0] conflict_cnt;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic [15:0] exp_cnt;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dual_slot_dmem_arbiter #(.AW(32), .DW(32), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_1           (req_1),
    .we_1            (we_1),
    .adr_1           (adr_1),
    .wd_1            (wd_1),
    .req_2           (req_2),
    .we_2            (we_2),
    .adr_2           (adr_2),
    .wd_2            (wd_2),
    .rd_1            (rd_1),
    .rd_2            (rd_2),
    .stall_m         (stall_m),
    .dmem_write      (dmem_write),
    .dmem_address    (dmem_address),
    .dmem_write_data (dmem_write_data),
    .dmem_read_data  (dmem_read_data),
    .conflict_cnt    (conflict_cnt)
  );

  // Behavioural data memory: combinational read, write at posedge.
  assign dmem_read_data = mem[dmem_address[5:2]];
  always @(posedge clk) if (dmem_write) mem[dmem_address[5:2]] <= dmem_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  function automatic logic [31:0] rnd_adr();
    return 32'h40 + (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic drive(input logic r1, w1, input logic [31:0] a1, d1,
                       input logic r2, w2, input logic [31:0] a2, d2);
    req_1 = r1; we_1 = w1; adr_1 = a1; wd_1 = d1;
    req_2 = r2; we_2 = w2; adr_2 = a2; wd_2 = d2;
  endtask

  // One M-stage instruction pair; inputs stay held through any stall cycle.
  task automatic do_op(input logic r1, w1, input logic [31:0] a1, d1,
                       input logic r2, w2, input logic [31:0] a2, d2);
    logic [31:0] exp_rd1;
    @(posedge clk); #1;
    drive(r1, w1, a1, d1, r2, w2, a2, d2);
    @(negedge clk);
    check("cnt_c0", 32'(conflict_cnt), 32'(exp_cnt));
    if (r1 && r2) begin
      exp_rd1 = ref_mem[idx(a1)];
      check("stall_c0", 32'(stall_m), 32'd1);
      check("we_c0", 32'(dmem_write), 32'(w1));
      check("adr_c0", dmem_address, a1);
      if (!w1) check("rd1_c0", rd_1, exp_rd1);
      if (w1) ref_mem[idx(a1)] = d1;
      if (exp_cnt != 16'hFFFF) exp_cnt++;
      @(negedge clk);
      check("stall_c1", 32'(stall_m), 32'd0);
      check("we_c1", 32'(dmem_write), 32'(w2));
      check("adr_c1", dmem_address, a2);
      check("rd1_c1", rd_1, exp_rd1);
      if (!w2) check("rd2_c1", rd_2, ref_mem[idx(a2)]);
      check("cnt_c1", 32'(conflict_cnt), 32'(exp_cnt));
      if (w2) ref_mem[idx(a2)] = d2;
    end else if (r1 || r2) begin
      check("stall_1", 32'(stall_m), 32'd0);
      check("we_1", 32'(dmem_write), 32'(r1 ? w1 : w2));
      check("adr_1", dmem_address, r1 ? a1 : a2);
      if (r1 && !w1) check("rd1_1", rd_1, ref_mem[idx(a1)]);
      if (r2 && !w2) check("rd2_1", rd_2, ref_mem[idx(a2)]);
      if (r1 && w1) ref_mem[idx(a1)] = d1;
      if (r2 && w2) ref_mem[idx(a2)] = d2;
    end else begin
      check("stall_0", 32'(stall_m), 32'd0);
      check("we_0", 32'(dmem_write), 32'd0);
      check("adr_0", dmem_address, a2);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    exp_cnt = '0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // 1: reset low three cycles, then idle with no request
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall_m), 32'd0);
    check("rst_we", 32'(dmem_write), 32'd0);
    check("rst_cnt", 32'(conflict_cnt), 32'd0);
    reset = 1'b1;
    do_op(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h48, 32'h5);

    // 2: single slot 1 load after preloading 0x40
    do_op(1'b1, 1'b1, 32'h40, 32'hAAAA, 1'b0, 1'b0, 32'h0, 32'h0);
    do_op(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t2_rd1", rd_1, 32'hAAAA);

    // 3: slot 1 store then slot 2 load of the same address
    do_op(1'b1, 1'b1, 32'h40, 32'h1234, 1'b1, 1'b0, 32'h40, 32'h0);
    check("t3_rd2", rd_2, 32'h1234);
    check("t3_cnt", 32'(conflict_cnt), 32'd1);

    // 4: both loads
    do_op(1'b1, 1'b1, 32'h40, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0);
    do_op(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h22);
    do_op(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
    check("t4_rd1", rd_1, 32'h11);
    check("t4_rd2", rd_2, 32'h22);

    // 5: both store to one address, slot 2 must persist
    do_op(1'b1, 1'b1, 32'h50, 32'h1, 1'b1, 1'b1, 32'h50, 32'h2);
    do_op(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t5_rd1", rd_1, 32'h2);

    // back-to-back conflicts
    for (int i = 0; i < 3; i++)
      do_op(1'b1, 1'b0, rnd_adr(), 32'h0, 1'b1, 1'b0, rnd_adr(), 32'h0);

    // 6: reset during SERVE2 drops the pending slot 2 store
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'h60, 32'hCAFE, 1'b1, 1'b1, 32'h64, 32'hDEAD);
    @(posedge clk); #1;
    check("t6_serve2_we", 32'(dmem_write), 32'd1);
    ref_mem[idx(32'h60)] = 32'hCAFE;
    reset = 1'b0;
    exp_cnt = '0;
    #1;
    check("t6_stall", 32'(stall_m), 32'd0);
    check("t6_we", 32'(dmem_write), 32'd0);
    check("t6_cnt", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    check("t6_we_hold", 32'(dmem_write), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 reset = 1'b1;
    do_op(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h64, 32'h0);
    do_op(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic r1, r2;
      r1 = ($urandom_range(0, 99) < 65);
      r2 = ($urandom_range(0, 99) < 65);
      do_op(r1, 1'($urandom_range(0, 1)), rnd_adr(), $urandom(),
            r2, 1'($urandom_range(0, 1)), rnd_adr(), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
